// File: rtl/test_sequencer.sv
// test_sequencer
//   Drives a memory-test transmitter with a programmable stream of read/write
//   commands. Parameters are latched when a start pulse arrives in IDLE; the
//   sequencer then walks pass_cnt+1 passes over word_cnt+1 addresses (base,
//   base+stride, ...) in one of four modes, optionally inserting idle gaps
//   after each accepted command. A compare error or an abort stops issue and
//   waits for the downstream units to go idle before reporting.
//
// Ports
//   clk_i, rst_n_i            clock (rising edge), async active-low reset
//   test_start_i/abort_i      start pulse (IDLE only) / abort request
//   test_mode_i               0 READ_ONLY, 1 WRITE_ONLY, 2 WRITE_AND_CHECK,
//                             3 WRITE_THEN_READ
//   word_cnt_i, pass_cnt_i    words per pass - 1, passes - 1
//   gap_i                     idle cycles after each non-final accept
//   base_addr_i, addr_stride_i  first address of each pass, increment
//   cmp_error_i               compare error (ends test with result=1)
//   cmp_busy_i, meas_busy_i, trans_busy_i  downstream busy, gate DRAIN exit
//   trans_ready_i             transmitter accepts the presented command
//   trans_valid_o/type_o/addr_o  command handshake (type 1 = read)
//   test_finished_o, test_result_o, test_aborted_o, busy_o, pass_num_o  status
module test_sequencer #(
    parameter int ADDR_W = 31,
    parameter int CNT_W  = 16,
    parameter int PASS_W = 8,
    parameter int GAP_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              test_start_i,
    input  logic              test_abort_i,
    input  logic [1:0]        test_mode_i,
    input  logic [CNT_W-1:0]  word_cnt_i,
    input  logic [PASS_W-1:0] pass_cnt_i,
    input  logic [GAP_W-1:0]  gap_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] addr_stride_i,
    input  logic              cmp_error_i,
    input  logic              cmp_busy_i,
    input  logic              meas_busy_i,
    input  logic              trans_busy_i,
    input  logic              trans_ready_i,
    output logic              trans_valid_o,
    output logic              trans_type_o,
    output logic [ADDR_W-1:0] trans_addr_o,
    output logic              test_finished_o,
    output logic              test_result_o,
    output logic              test_aborted_o,
    output logic              busy_o,
    output logic [PASS_W-1:0] pass_num_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t state_q, state_n;

    logic              valid_q, valid_n;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  word_cnt_q, word_idx_q;
    logic [PASS_W-1:0] pass_cnt_q, pass_idx_q;
    logic [GAP_W-1:0]  gap_q, gap_cnt_q;
    logic [ADDR_W-1:0] base_q, stride_q, addr_q;
    // WRITE_AND_CHECK: 0 = write, 1 = read of the current address.
    // WRITE_THEN_READ: 0 = write sweep, 1 = read sweep of the pass.
    logic              phase_q;
    logic              finished_q, result_q, aborted_q;

    logic accept, stop, word_last, pass_last, pass_end, final_cmd;
    logic drain_done, cmd_read;

    assign accept     = valid_q && trans_ready_i;
    assign stop       = (state_q != S_IDLE) && (cmp_error_i || test_abort_i);
    assign word_last  = (word_idx_q == word_cnt_q);
    assign pass_last  = (pass_idx_q == pass_cnt_q);
    // Two-phase modes only end a pass on the last word of the read phase.
    assign pass_end   = mode_q[1] ? (phase_q && word_last) : word_last;
    assign final_cmd  = pass_end && pass_last;
    assign drain_done = !(cmp_busy_i || meas_busy_i || trans_busy_i);

    always_comb begin
        cmd_read = phase_q;
        case (mode_q)
            2'd0:    cmd_read = 1'b1;
            2'd1:    cmd_read = 1'b0;
            default: cmd_read = phase_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state_q;
        valid_n = valid_q;
        case (state_q)
            S_IDLE: begin
                valid_n = 1'b0;
                if (test_start_i) state_n = S_LOAD;
            end
            S_LOAD: begin
                valid_n = 1'b0;
                state_n = S_RUN;
            end
            S_RUN: begin
                // First RUN cycle after LOAD raises valid; afterwards valid
                // only falls on an accept that ends or pauses the stream.
                if (!valid_q) begin
                    valid_n = 1'b1;
                end else if (accept) begin
                    if (final_cmd) begin
                        state_n = S_DRAIN;
                        valid_n = 1'b0;
                    end else if (gap_q != '0) begin
                        state_n = S_GAP;
                        valid_n = 1'b0;
                    end
                end
            end
            S_GAP: begin
                // Valid is raised on the same edge that leaves GAP so the
                // low window is exactly gap cycles long.
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_n = S_RUN;
                    valid_n = 1'b1;
                end
            end
            S_DRAIN: begin
                valid_n = 1'b0;
                if (drain_done) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
            end
        endcase
        if (stop) begin
            state_n = S_DRAIN;
            valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q     <= '0;
            word_cnt_q <= '0;
            pass_cnt_q <= '0;
            gap_q      <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            addr_q     <= '0;
            word_idx_q <= '0;
            pass_idx_q <= '0;
            gap_cnt_q  <= '0;
            phase_q    <= 1'b0;
            finished_q <= 1'b0;
            result_q   <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (test_start_i) begin
                        mode_q     <= test_mode_i;
                        word_cnt_q <= word_cnt_i;
                        pass_cnt_q <= pass_cnt_i;
                        gap_q      <= gap_i;
                        base_q     <= base_addr_i;
                        stride_q   <= addr_stride_i;
                        word_idx_q <= '0;
                        pass_idx_q <= '0;
                        phase_q    <= 1'b0;
                        finished_q <= 1'b0;
                        result_q   <= 1'b0;
                        aborted_q  <= 1'b0;
                    end
                end
                S_LOAD: addr_q <= base_q;
                S_RUN: begin
                    // An error/abort in the same cycle wins over the accept.
                    if (accept && !stop && !final_cmd) begin
                        gap_cnt_q <= gap_q;
                        if (pass_end) begin
                            pass_idx_q <= pass_idx_q + PASS_W'(1);
                            word_idx_q <= '0;
                            phase_q    <= 1'b0;
                            addr_q     <= base_q;
                        end else begin
                            case (mode_q)
                                2'd2: begin
                                    if (!phase_q) begin
                                        phase_q <= 1'b1;
                                    end else begin
                                        phase_q    <= 1'b0;
                                        word_idx_q <= word_idx_q + CNT_W'(1);
                                        addr_q     <= addr_q + stride_q;
                                    end
                                end
                                2'd3: begin
                                    if (word_last) begin
                                        phase_q    <= 1'b1;
                                        word_idx_q <= '0;
                                        addr_q     <= base_q;
                                    end else begin
                                        word_idx_q <= word_idx_q + CNT_W'(1);
                                        addr_q     <= addr_q + stride_q;
                                    end
                                end
                                default: begin
                                    word_idx_q <= word_idx_q + CNT_W'(1);
                                    addr_q     <= addr_q + stride_q;
                                end
                            endcase
                        end
                    end
                end
                S_GAP: gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                default: ;
            endcase
            // Error outranks abort; a test reports at most one of the two.
            if (stop) begin
                if (cmp_error_i) begin
                    result_q  <= 1'b1;
                    aborted_q <= 1'b0;
                end else if (!result_q) begin
                    aborted_q <= 1'b1;
                end
            end
            if (state_q == S_DRAIN && state_n == S_IDLE) finished_q <= 1'b1;
        end
    end

    assign trans_valid_o   = valid_q;
    assign trans_type_o    = valid_q && cmd_read;
    assign trans_addr_o    = addr_q;
    assign test_finished_o = finished_q;
    assign test_result_o   = result_q;
    assign test_aborted_o  = aborted_q;
    assign busy_o          = (state_q != S_IDLE);
    assign pass_num_o      = pass_idx_q;

endmodule

// File: tb/tb_test_sequencer.sv
module tb_test_sequencer;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        test_start_i, test_abort_i;
    logic [1:0]  test_mode_i;
    logic [15:0] word_cnt_i;
    logic [7:0]  pass_cnt_i, gap_i;
    logic [30:0] base_addr_i, addr_stride_i;
    logic        cmp_error_i, cmp_busy_i, meas_busy_i, trans_busy_i, trans_ready_i;
    logic        trans_valid_o, trans_type_o;
    logic [30:0] trans_addr_o;
    logic        test_finished_o, test_result_o, test_aborted_o, busy_o;
    logic [7:0]  pass_num_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    test_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .test_start_i(test_start_i), .test_abort_i(test_abort_i),
        .test_mode_i(test_mode_i), .word_cnt_i(word_cnt_i),
        .pass_cnt_i(pass_cnt_i), .gap_i(gap_i),
        .base_addr_i(base_addr_i), .addr_stride_i(addr_stride_i),
        .cmp_error_i(cmp_error_i), .cmp_busy_i(cmp_busy_i),
        .meas_busy_i(meas_busy_i), .trans_busy_i(trans_busy_i),
        .trans_ready_i(trans_ready_i),
        .trans_valid_o(trans_valid_o), .trans_type_o(trans_type_o),
        .trans_addr_o(trans_addr_o),
        .test_finished_o(test_finished_o), .test_result_o(test_result_o),
        .test_aborted_o(test_aborted_o), .busy_o(busy_o),
        .pass_num_o(pass_num_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, trans_valid_o}, 0);
        chk({tag, "_type"}, {31'd0, trans_type_o}, 0);
        chk({tag, "_addr"}, {1'b0, trans_addr_o}, 0);
        chk({tag, "_fin"}, {31'd0, test_finished_o}, 0);
        chk({tag, "_res"}, {31'd0, test_result_o}, 0);
        chk({tag, "_abt"}, {31'd0, test_aborted_o}, 0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 0);
        chk({tag, "_pass"}, {24'd0, pass_num_o}, 0);
    endtask

    task automatic setup(input logic [1:0] m, input logic [15:0] w, input logic [7:0] p,
                         input logic [7:0] g, input logic [30:0] b, input logic [30:0] s);
        test_mode_i = m; word_cnt_i = w; pass_cnt_i = p; gap_i = g;
        base_addr_i = b; addr_stride_i = s;
    endtask

    // Called at a negedge in IDLE; ends at the negedge where the first
    // command must be visible (two rising edges after the sampling edge).
    task automatic do_start(input string tag, input logic [30:0] b);
        test_start_i = 1'b1;
        @(negedge clk);
        test_start_i = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy_o}, 1);
        chk({tag, "_v0"}, {31'd0, trans_valid_o}, 0);
        chk({tag, "_fclr"}, {29'd0, test_finished_o, test_result_o, test_aborted_o}, 0);
        @(negedge clk);
        chk({tag, "_v1"}, {31'd0, trans_valid_o}, 0);
        @(negedge clk);
        chk({tag, "_v2"}, {31'd0, trans_valid_o}, 1);
        chk({tag, "_a2"}, {1'b0, trans_addr_o}, {1'b0, b});
    endtask

    // Checks the next accepted command; returns its cycle stamp and leaves
    // the bench at the following negedge.
    task automatic wait_cmd(input string tag, input logic et, input logic [30:0] ea,
                            input logic [7:0] ep, output int at);
        bit found = 0;
        at = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            if (trans_valid_o && trans_ready_i) begin
                chk({tag, "_type"}, {31'd0, trans_type_o}, {31'd0, et});
                chk({tag, "_addr"}, {1'b0, trans_addr_o}, {1'b0, ea});
                chk({tag, "_pass"}, {24'd0, pass_num_o}, {24'd0, ep});
                at = cyc;
                found = 1;
            end
            @(negedge clk);
        end
        if (!found) begin
            tests++; fails++;
            $error("FAIL %s_timeout: got no command expected one", tag);
        end
    endtask

    task automatic wait_fin(input string tag, input logic res, input logic abt);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (test_finished_o) found = 1;
            else @(negedge clk);
        end
        tests++;
        if (!found) begin
            fails++;
            $error("FAIL %s_timeout: got finished=0 expected 1", tag);
        end
        chk({tag, "_res"}, {31'd0, test_result_o}, {31'd0, res});
        chk({tag, "_abt"}, {31'd0, test_aborted_o}, {31'd0, abt});
        chk({tag, "_busy"}, {31'd0, busy_o}, 0);
        chk({tag, "_valid"}, {31'd0, trans_valid_o}, 0);
    endtask

    logic        te [0:7];
    logic [30:0] ta [0:7];
    logic [7:0]  tp [0:7];

    initial begin
        int t, tprev;
        rst_n_i = 1'b0; test_start_i = 0; test_abort_i = 0; cmp_error_i = 0;
        cmp_busy_i = 0; meas_busy_i = 0; trans_busy_i = 0; trans_ready_i = 1;
        setup(2'd0, 16'd0, 8'd0, 8'd0, 31'd0, 31'd0);
        @(negedge clk);
        chk_zero("rst");
        rst_n_i = 1'b1;
        @(negedge clk);

        // WRITE_ONLY, back-to-back
        setup(2'd1, 16'd3, 8'd0, 8'd0, 31'h100, 31'd4);
        do_start("wo", 31'h100);
        for (int i = 0; i < 4; i++) begin
            tprev = t;
            wait_cmd($sformatf("wo%0d", i), 1'b0, 31'h100 + 31'(4 * i), 8'd0, t);
            if (i > 0) chk($sformatf("wo%0d_gap", i), t - tprev, 1);
        end
        wait_fin("wo_fin", 1'b0, 1'b0);

        // WRITE_AND_CHECK, two passes
        setup(2'd2, 16'd1, 8'd1, 8'd0, 31'd0, 31'd4);
        do_start("wc", 31'd0);
        for (int i = 0; i < 8; i++) begin
            te[i] = i[0]; ta[i] = i[1] ? 31'd4 : 31'd0; tp[i] = {7'd0, i[2]};
        end
        for (int i = 0; i < 8; i++) wait_cmd($sformatf("wc%0d", i), te[i], ta[i], tp[i], t);
        wait_fin("wc_fin", 1'b0, 1'b0);

        // WRITE_THEN_READ, gap 2; inputs changed and start pulsed mid-run
        setup(2'd3, 16'd2, 8'd0, 8'd2, 31'd0, 31'd4);
        do_start("wr", 31'd0);
        for (int i = 0; i < 6; i++) begin
            tprev = t;
            wait_cmd($sformatf("wr%0d", i), i >= 3, 31'(4 * (i % 3)), 8'd0, t);
            if (i > 0) chk($sformatf("wr%0d_gap", i), t - tprev, 3);
            if (i == 0) begin
                test_start_i = 1'b1;
                setup(2'd0, 16'd9, 8'd5, 8'd0, 31'h40, 31'd8);
                @(negedge clk);
                test_start_i = 1'b0;
                chk("wr_gaplow", {31'd0, trans_valid_o}, 0);
            end
        end
        wait_fin("wr_fin", 1'b0, 1'b0);

        // Backpressure on the second command
        setup(2'd1, 16'd3, 8'd0, 8'd0, 31'h200, 31'd4);
        do_start("bp", 31'h200);
        wait_cmd("bp0", 1'b0, 31'h200, 8'd0, t);
        trans_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", i),
                {trans_valid_o, trans_type_o, trans_addr_o}, {1'b1, 1'b0, 31'h204});
        end
        trans_ready_i = 1'b1;
        for (int i = 1; i < 4; i++)
            wait_cmd($sformatf("bp%0d", i), 1'b0, 31'h200 + 31'(4 * i), 8'd0, t);
        wait_fin("bp_fin", 1'b0, 1'b0);

        // Compare error after the 2nd accept, transmitter busy 3 more cycles
        setup(2'd1, 16'd7, 8'd0, 8'd0, 31'd0, 31'd4);
        do_start("er", 31'd0);
        wait_cmd("er0", 1'b0, 31'd0, 8'd0, t);
        wait_cmd("er1", 1'b0, 31'd4, 8'd0, t);
        cmp_error_i = 1'b1; trans_busy_i = 1'b1;
        @(negedge clk);
        cmp_error_i = 1'b0;
        chk("er_vdrop", {31'd0, trans_valid_o}, 0);
        chk("er_res", {31'd0, test_result_o}, 1);
        @(negedge clk);
        @(negedge clk);
        chk("er_nofin", {31'd0, test_finished_o}, 0);
        trans_busy_i = 1'b0;
        @(negedge clk);
        chk("er_fin", {31'd0, test_finished_o}, 1);
        wait_fin("er_end", 1'b1, 1'b0);

        // Address wrap at ADDR_W=31
        setup(2'd0, 16'd2, 8'd0, 8'd0, 31'h7FFFFFF8, 31'd4);
        do_start("wp", 31'h7FFFFFF8);
        wait_cmd("wp0", 1'b1, 31'h7FFFFFF8, 8'd0, t);
        wait_cmd("wp1", 1'b1, 31'h7FFFFFFC, 8'd0, t);
        wait_cmd("wp2", 1'b1, 31'h00000000, 8'd0, t);
        wait_fin("wp_fin", 1'b0, 1'b0);

        // Abort mid-run
        setup(2'd0, 16'd7, 8'd0, 8'd0, 31'h10, 31'd4);
        do_start("ab", 31'h10);
        wait_cmd("ab0", 1'b1, 31'h10, 8'd0, t);
        test_abort_i = 1'b1;
        @(negedge clk);
        test_abort_i = 1'b0;
        chk("ab_vdrop", {31'd0, trans_valid_o}, 0);
        wait_fin("ab_fin", 1'b0, 1'b1);

        // Error and abort together: only result
        do_start("ea", 31'h10);
        wait_cmd("ea0", 1'b1, 31'h10, 8'd0, t);
        test_abort_i = 1'b1; cmp_error_i = 1'b1;
        @(negedge clk);
        test_abort_i = 1'b0; cmp_error_i = 1'b0;
        wait_fin("ea_fin", 1'b1, 1'b0);

        // Asynchronous reset mid-test
        do_start("rm", 31'h10);
        wait_cmd("rm0", 1'b1, 31'h10, 8'd0, t);
        #1 rst_n_i = 1'b0;
        #1 chk_zero("rm");
        @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);
        chk("rm_idle", {31'd0, busy_o}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 31, transaction address width.
REQ-002 SHALL have parameter CNT_W, default 16, word-count width.
REQ-003 SHALL have parameter PASS_W, default 8, pass-count width.
REQ-004 SHALL have parameter GAP_W, default 8, inter-command gap width.
REQ-005 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port test_start_i  input  1  start pulse.
REQ-008 SHALL have port test_abort_i  input  1  abort request.
REQ-009 SHALL have port test_mode_i  input  2  mode: 0 READ_ONLY, 1 WRITE_ONLY, 2 WRITE_AND_CHECK, 3 WRITE_THEN_READ.
REQ-010 SHALL have port word_cnt_i  input  CNT_W  words per pass minus one.
REQ-011 SHALL have port pass_cnt_i  input  PASS_W  passes minus one.
REQ-012 SHALL have port gap_i  input  GAP_W  idle cycles after each accepted command.
REQ-013 SHALL have port base_addr_i  input  ADDR_W  first address of each pass.
REQ-014 SHALL have port addr_stride_i  input  ADDR_W  address increment.
REQ-015 SHALL have ports cmp_error_i, cmp_busy_i, meas_busy_i, trans_busy_i  input  1 each  compare error, compare, measure and transmitter busy.
REQ-016 SHALL have port trans_ready_i  input  1  transmitter accepts command.
REQ-017 SHALL have ports trans_valid_o  output  1  command valid; trans_type_o  output  1  1 = read, 0 = write; trans_addr_o  output  ADDR_W  command address.
REQ-018 SHALL have ports test_finished_o, test_result_o (1 = error), test_aborted_o, busy_o  output  1 each; pass_num_o  output  PASS_W  current pass index.

Function
REQ-019 SHALL latch all test parameters in IDLE on the edge sampling test_start_i=1; test_start_i outside IDLE SHALL be ignored.
REQ-020 SHALL implement states IDLE, LOAD, RUN, GAP, DRAIN: IDLE->LOAD on start; LOAD->RUN; RUN->GAP on accept when gap>0 and more commands remain; GAP->RUN after gap cycles; RUN->DRAIN on final accept; DRAIN->IDLE when cmp_busy_i, meas_busy_i and trans_busy_i are all 0.
REQ-021 SHALL define accept as trans_valid_o && trans_ready_i in one cycle.
REQ-022 SHALL assert trans_valid_o on the second rising edge after the start-sampling edge, with trans_addr_o = base_addr_i.
REQ-023 SHALL hold trans_valid_o, trans_type_o and trans_addr_o stable while trans_valid_o=1 and trans_ready_i=0.
REQ-024 SHALL, with gap=0, present the next command the cycle after an accept with trans_valid_o held high.
REQ-025 SHALL, with gap=G>0, deassert trans_valid_o for exactly G cycles after each non-final accept.
REQ-026 SHALL issue word_cnt+1 commands per pass in READ_ONLY (all reads) and WRITE_ONLY (all writes).
REQ-027 SHALL in WRITE_AND_CHECK issue write then read per address: 2*(word_cnt+1) commands per pass; the address advances only after the read.
REQ-028 SHALL in WRITE_THEN_READ issue word_cnt+1 writes, reload base address, then word_cnt+1 reads per pass.
REQ-029 SHALL run pass_cnt+1 passes, each restarting at base_addr_i; pass_num_o SHALL count 0..pass_cnt.
REQ-030 SHALL advance the address by addr_stride_i modulo 2^ADDR_W (wrap-around, no flag).
REQ-031 SHALL, on cmp_error_i=1 in any non-IDLE state, drop trans_valid_o next edge, set test_result_o=1 and enter DRAIN.
REQ-032 SHALL, on test_abort_i=1 in any non-IDLE state, drop trans_valid_o next edge, set test_aborted_o=1 and enter DRAIN.
REQ-033 SHALL, on simultaneous error and abort, set only test_result_o.
REQ-034 SHALL treat an error coinciding with the final accept as an error.
REQ-035 SHALL set test_finished_o=1 on the DRAIN->IDLE edge, held until the next accepted start.
REQ-036 SHALL clear test_finished_o, test_result_o and test_aborted_o on an accepted start.
REQ-037 SHALL drive busy_o=1 in every state except IDLE.
REQ-038 SHALL accept test_mode_i values 0-3 only, all of which are legal.

Reset
REQ-039 SHALL, on rst_n_i=0 at any time (including mid-test), force IDLE and set all outputs to 0 asynchronously.

Verification
REQ-040 WRITE_ONLY, word_cnt=3, pass_cnt=0, gap=0, base=0x100, stride=4, ready=1 -> writes to 0x100, 0x104, 0x108, 0x10C on consecutive cycles; finished=1, result=0.
REQ-041 WRITE_AND_CHECK, word_cnt=1, pass_cnt=1, base=0, stride=4 -> W0 R0 W4 R4 with pass_num_o=0, then W0 R0 W4 R4 with pass_num_o=1.
REQ-042 WRITE_THEN_READ, word_cnt=2, gap=2 -> W0 W4 W8 R0 R4 R8, valid low exactly 2 cycles between commands.
REQ-043 ready=0 for 5 cycles during the second command -> valid, type and addr unchanged; sequence resumes intact.
REQ-044 cmp_error_i pulse after the 2nd accept, trans_busy_i high 3 more cycles -> valid=0 next edge; finished=1 after busy falls; result=1.
REQ-045 ADDR_W=31, base=0x7FFFFFF8, stride=4, word_cnt=2 -> addresses 0x7FFFFFF8, 0x7FFFFFFC, 0x00000000; abort during second run -> aborted=1, result=0; rst_n_i low mid-test -> all outputs 0.
